// File: rtl/fpu_result_cvt.sv
// Converts a signed 64-bit fixed-point FPU result to IEEE-754 binary32 over a 4-state handshake FSM.
// Optional build macro FPU_RESULT_RNE_EN selects round-to-nearest-even; otherwise the result truncates toward zero.
module fpu_result_cvt #(
    parameter int FRAC_BITS = 32,
    parameter int TAG_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_inexact
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_PACK,
        S_OUT
    } state_e;

    // Biased exponent of a value whose leading one sits at bit 63 of the magnitude.
    localparam logic [7:0] EXP_BASE = 8'(63 - FRAC_BITS + 127);

    state_e           state_q, state_d;
    logic             sign_q, sign_d;
    logic [63:0]      frac_q, frac_d;
    logic [5:0]       lz_q, lz_d;
    logic             zero_q, zero_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      data_q, data_d;
    logic             inexact_q, inexact_d;

    logic [5:0]       lz_cnt;
    logic [23:0]      mant;
    logic             guard_bit;
    logic             sticky_bit;
    logic             round_up;
    logic [24:0]      mant_rnd;
    logic [7:0]       exp_val;
    logic [22:0]      mant_field;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lz_cnt = 6'd63;
        for (int i = 0; i < 64; i++) begin
            if (frac_q[i]) lz_cnt = 6'(63 - i);
        end
    end

    always_comb begin
        mant       = frac_q[63:40];
        guard_bit  = frac_q[39];
        sticky_bit = |frac_q[38:0];
`ifdef FPU_RESULT_RNE_EN
        round_up   = guard_bit & (sticky_bit | mant[0]);
`else
        round_up   = 1'b0;
`endif
        mant_rnd   = {1'b0, mant} + {24'd0, round_up};
        exp_val    = EXP_BASE - {2'b00, lz_q} + {7'd0, mant_rnd[24]};
        // A rounding carry clears the hidden bit; the fraction is then exactly 2^23 with nothing below it.
        mant_field = mant_rnd[23] ? mant_rnd[22:0] : 23'd0;
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        frac_d    = frac_q;
        lz_d      = lz_q;
        zero_d    = zero_q;
        tag_d     = tag_q;
        data_d    = data_q;
        inexact_d = inexact_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[63];
                    frac_d  = in_data[63] ? (~in_data + 64'd1) : in_data;
                    tag_d   = in_tag;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                lz_d    = lz_cnt;
                frac_d  = frac_q << lz_cnt;
                zero_d  = (frac_q == 64'd0);
                state_d = S_PACK;
            end
            S_PACK: begin
                if (zero_q) begin
                    data_d    = 32'd0;
                    inexact_d = 1'b0;
                end else begin
                    data_d    = {sign_q, exp_val, mant_field};
                    inexact_d = guard_bit | sticky_bit;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is written with <= only, so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            frac_q    <= 64'd0;
            lz_q      <= 6'd0;
            zero_q    <= 1'b0;
            tag_q     <= '0;
            data_q    <= 32'd0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            frac_q    <= frac_d;
            lz_q      <= lz_d;
            zero_q    <= zero_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            inexact_q <= inexact_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign out_data    = data_q;
    assign out_tag     = tag_q;
    assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fpu_result_cvt.sv
// Self-checking bench for fpu_result_cvt: directed cases, backpressure, mid-flight reset and randomized traffic
// checked against an arithmetic fp32 model through a scoreboard.
module tb_fpu_result_cvt;

    localparam int FRAC_BITS = 32;
    localparam int TAG_W     = 5;
    localparam int N_RANDOM  = 300;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_inexact;

    typedef struct {
        logic [31:0]      data;
        logic             inx;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fpu_result_cvt #(
        .FRAC_BITS(FRAC_BITS),
        .TAG_W    (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: value = d / 2^FRAC_BITS; locate the top set bit, keep 24 significant bits, round on the remainder.
    function automatic logic [32:0] model(input logic [63:0] d);
        logic        sign;
        logic [63:0] mag;
        logic [63:0] m;
        logic [63:0] rem;
        logic [7:0]  e;
        logic        inx;
        logic        up;
        int          p;
        sign = d[63];
        mag  = sign ? (64'd0 - d) : d;
        if (mag == 64'd0) return 33'd0;
        p = 63;
        while (!mag[p]) p--;
        e = 8'(p - FRAC_BITS + 127);
        if (p >= 23) begin
            m   = mag >> (p - 23);
            rem = mag - (m << (p - 23));
        end else begin
            m   = mag << (23 - p);
            rem = 64'd0;
        end
        inx = (rem != 64'd0);
        up  = 1'b0;
`ifdef FPU_RESULT_RNE_EN
        if (p >= 24) begin
            logic [63:0] half;
            half = 64'd1 << (p - 24);
            up   = (rem > half) || (rem == half && m[0]);
        end
`endif
        m = m + {63'd0, up};
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            e = e + 8'd1;
        end
        return {inx, sign, e, m[22:0]};
    endfunction

    task automatic monitor();
        bit               pend = 0;
        logic [31:0]      pd   = '0;
        logic [TAG_W-1:0] pt   = '0;
        logic             pi   = 1'b0;
        logic [32:0]      r;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                pend = 0;
                continue;
            end
            if (pend) begin
                check("hold valid", 64'(out_valid), 64'd1);
                check("hold data", 64'(out_data), 64'(pd));
                check("hold tag", 64'(out_tag), 64'(pt));
                check("hold inexact", 64'(out_inexact), 64'(pi));
            end
            if (out_valid) check("in_ready while busy", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("scoreboard depth", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb data", 64'(out_data), 64'(e.data));
                    check("sb inexact", 64'(out_inexact), 64'(e.inx));
                    check("sb tag", 64'(out_tag), 64'(e.tag));
                end
            end
            pend = out_valid && !out_ready;
            pd   = out_data;
            pt   = out_tag;
            pi   = out_inexact;
            if (in_valid && in_ready) begin
                r = model(in_data);
                sb.push_back('{data: r[31:0], inx: r[32], tag: in_tag});
            end
        end
    endtask

    // Offers one value, waits for acceptance and for out_valid, then checks against literal expectations.
    task automatic convert(input string name, input logic [63:0] d, input logic [TAG_W-1:0] t,
                           input logic [31:0] exp_data, input logic exp_inx, input bit check_lat);
        bit acc = 0;
        int lat = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
        end
        check({name, " accepted"}, 64'(acc), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (check_lat) check({name, " latency"}, 64'(lat), 64'd3);
        check({name, " data"}, 64'(out_data), 64'(exp_data));
        check({name, " inexact"}, 64'(out_inexact), 64'(exp_inx));
        check({name, " tag"}, 64'(out_tag), 64'(t));
    endtask

    task automatic main_seq();
        logic [31:0]      held_data;
        logic [TAG_W-1:0] held_tag;
        logic [63:0]      d;
        int               sent;
        int               guard;
        bit               acc;
        logic [31:0]      big_exp;

`ifdef FPU_RESULT_RNE_EN
        big_exp = 32'h4B80_0000;
`else
        big_exp = 32'h4B7F_FFFF;
`endif
        check("model 1.0", 64'(model(64'h0000_0001_0000_0000)), 64'h0_3F80_0000);
        check("model -1.5", 64'(model(64'hFFFF_FFFE_8000_0000)), 64'h0_BFC0_0000);
        check("model zero", 64'(model(64'h0)), 64'h0);
        check("model -2^31", 64'(model(64'h8000_0000_0000_0000)), 64'h0_CF00_0000);
        check("model carry", 64'(model(64'h00FF_FFFF_FF00_0000)), {31'd0, 1'b1, big_exp});
        check("model 2^-32", 64'(model(64'h1)), 64'h0_2F80_0000);

        #3;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        check("reset out_inexact", 64'(out_inexact), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        convert("one", 64'h0000_0001_0000_0000, 5'd5, 32'h3F80_0000, 1'b0, 1'b1);
        convert("neg1p5", 64'hFFFF_FFFE_8000_0000, 5'd9, 32'hBFC0_0000, 1'b0, 1'b1);
        convert("zero", 64'h0, 5'd17, 32'h0000_0000, 1'b0, 1'b1);
        convert("min", 64'h8000_0000_0000_0000, 5'd31, 32'hCF00_0000, 1'b0, 1'b0);
        convert("carry", 64'h00FF_FFFF_FF00_0000, 5'd3, big_exp, 1'b1, 1'b0);
        convert("tiny", 64'h0000_0000_0000_0001, 5'd1, 32'h2F80_0000, 1'b0, 1'b0);

        // Backpressure: first result held for 5 cycles while a second value waits at the input.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hFFFF_FFFF_0000_0000;
        in_tag    = 5'd12;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
        end
        check("bp first accepted", 64'(acc), 64'd1);
        @(posedge clk);
        #1;
        in_data = 64'h0000_0003_0000_0000;
        in_tag  = 5'd22;
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        check("bp first valid", 64'(out_valid), 64'd1);
        held_data = out_data;
        held_tag  = out_tag;
        check("bp first data", 64'(held_data), 64'hBF80_0000);
        check("bp first tag", 64'(held_tag), 64'd12);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp stall data", 64'(out_data), 64'(held_data));
            check("bp stall tag", 64'(out_tag), 64'(held_tag));
            check("bp stall in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp handshake pending", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("bp second offered", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        check("bp second data", 64'(out_data), 64'h4040_0000);
        check("bp second tag", 64'(out_tag), 64'd22);
        @(posedge clk);

        // Reset while the converter is normalizing.
        #1;
        in_valid = 1'b1;
        in_data  = 64'h0000_0005_8000_0001;
        in_tag   = 5'd7;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort out_data", 64'(out_data), 64'd0);
        check("abort out_tag", 64'(out_tag), 64'd0);
        check("abort out_inexact", 64'(out_inexact), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        convert("after reset", 64'h0000_0002_0000_0000, 5'd10, 32'h4000_0000, 1'b0, 1'b1);

        // Randomized traffic with random gaps and output backpressure.
        sent  = 0;
        guard = 0;
        acc   = 0;
        @(posedge clk);
        #1;
        while (sent < N_RANDOM && guard < 20000) begin
            guard++;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            if (!in_valid && sent < N_RANDOM && $urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 9))
                    0: d = 64'h0;
                    1: d = 64'h8000_0000_0000_0000;
                    default: begin
                        d = {$urandom, $urandom} >> $urandom_range(0, 63);
                        if ($urandom_range(0, 1) != 0) d = 64'd0 - d;
                    end
                endcase
                in_valid = 1'b1;
                in_data  = d;
                in_tag   = TAG_W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        check("random all sent", 64'(sent), 64'(N_RANDOM));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && (sb.size() != 0 || out_valid); k++) @(negedge clk);
        check("drain scoreboard", 64'(sb.size()), 64'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        in_tag    = '0;
        out_ready = 1'b0;
        fork
            monitor();
            main_seq();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_any
    end

endmodule
